// File: rtl/advanced_counter_pkg.sv
// Shared types and default timing for the button debouncer / auto-repeat front end.
// State values match the encoding used by the downstream digit-counter logic.
package advanced_counter_pkg;

  typedef enum logic [2:0] {
    StIdle        = 3'd0,
    StPressWait   = 3'd1,
    StHeld        = 3'd2,
    StRepeat      = 3'd3,
    StReleaseWait = 3'd4
  } state_e;

  localparam int unsigned DefaultChannels       = 2;
  localparam int unsigned DefaultDebounceCycles = 10000;
  localparam int unsigned DefaultRepeatDelay    = 500000;
  localparam int unsigned DefaultRepeatPeriod   = 100000;

  // Counter width large enough to hold (largest cycle parameter - 1).
  function automatic int unsigned cnt_width(int unsigned a, int unsigned b, int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounce + auto-repeat channel: FSM with a shared cycle counter.
// event_o is the combinational next-cycle event, registered and merged by the top.
module debounce_channel
  import advanced_counter_pkg::*;
#(
  parameter int unsigned DebounceCycles = DefaultDebounceCycles,
  parameter int unsigned RepeatDelay    = DefaultRepeatDelay,
  parameter int unsigned RepeatPeriod   = DefaultRepeatPeriod
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  input  logic repeat_en_i,
  output logic inc_pulse_o,
  output logic btn_stable_o,
  output logic event_o
);

  localparam int unsigned CntW = cnt_width(DebounceCycles, RepeatDelay, RepeatPeriod);
  localparam logic [CntW-1:0] DebLast    = CntW'(DebounceCycles - 1);
  localparam logic [CntW-1:0] DelayLast  = CntW'(RepeatDelay - 1);
  localparam logic [CntW-1:0] PeriodLast = CntW'(RepeatPeriod - 1);

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            pulse_q, pulse_d;
  logic            stable_q, stable_d;
  logic            release_d;
  logic [CntW-1:0] term;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pulse_d   = 1'b0;
    release_d = 1'b0;
    term      = (state_q == StHeld) ? DelayLast : PeriodLast;
    unique case (state_q)
      StIdle: begin
        if (btn_i) begin
          state_d = StPressWait;
          cnt_d   = '0;
        end
      end
      StPressWait: begin
        if (!btn_i) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (cnt_q == DebLast) begin
          state_d = StHeld;
          cnt_d   = '0;
          pulse_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StHeld, StRepeat: begin
        if (!btn_i) begin
          state_d = StReleaseWait;
          cnt_d   = '0;
        end else if (!repeat_en_i) begin
          // Parked at zero so re-enabling always counts a full interval.
          cnt_d = '0;
        end else if (cnt_q == term) begin
          state_d = StRepeat;
          cnt_d   = '0;
          pulse_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StReleaseWait: begin
        if (btn_i) begin
          state_d = StHeld;
          cnt_d   = '0;
        end else if (cnt_q == DebLast) begin
          state_d   = StIdle;
          cnt_d     = '0;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
    stable_d = (state_d == StHeld) || (state_d == StRepeat) || (state_d == StReleaseWait);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      pulse_q  <= 1'b0;
      stable_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pulse_q  <= pulse_d;
      stable_q <= stable_d;
    end
  end

  assign inc_pulse_o  = pulse_q;
  assign btn_stable_o = stable_q;
  assign event_o      = pulse_d | release_d;

endmodule

// File: rtl/button_repeat_debouncer.sv
// Multi-channel debouncer with auto-repeat increment pulses and a merged refresh strobe.
// Channels are independent; any_event is registered so it lines up with inc_pulse.
module button_repeat_debouncer
  import advanced_counter_pkg::*;
#(
  parameter int unsigned CHANNELS        = DefaultChannels,
  parameter int unsigned DEBOUNCE_CYCLES = DefaultDebounceCycles,
  parameter int unsigned REPEAT_DELAY    = DefaultRepeatDelay,
  parameter int unsigned REPEAT_PERIOD   = DefaultRepeatPeriod
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] btn_in,
  input  logic                repeat_en,
  output logic [CHANNELS-1:0] inc_pulse,
  output logic [CHANNELS-1:0] btn_stable,
  output logic                any_event
);

  logic [CHANNELS-1:0] ch_event;
  logic                any_event_q;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    debounce_channel #(
      .DebounceCycles(DEBOUNCE_CYCLES),
      .RepeatDelay   (REPEAT_DELAY),
      .RepeatPeriod  (REPEAT_PERIOD)
    ) u_ch (
      .clk_i       (clk),
      .rst_i       (reset),
      .btn_i       (btn_in[g]),
      .repeat_en_i (repeat_en),
      .inc_pulse_o (inc_pulse[g]),
      .btn_stable_o(btn_stable[g]),
      .event_o     (ch_event[g])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      any_event_q <= 1'b0;
    end else begin
      any_event_q <= |ch_event;
    end
  end

  assign any_event = any_event_q;

endmodule

// File: tb/tb_button_repeat_debouncer.sv
// Directed bench for button_repeat_debouncer with short timing parameters.
module tb_button_repeat_debouncer;

  localparam int unsigned Ch = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [Ch-1:0] btn_in;
  logic          repeat_en;
  logic [Ch-1:0] inc_pulse;
  logic [Ch-1:0] btn_stable;
  logic          any_event;

  int n_assert = 0;
  int n_fail   = 0;

  button_repeat_debouncer #(
    .CHANNELS       (Ch),
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (10),
    .REPEAT_PERIOD  (3)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_in    (btn_in),
    .repeat_en (repeat_en),
    .inc_pulse (inc_pulse),
    .btn_stable(btn_stable),
    .any_event (any_event)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input int k, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s at edge %0d: observed %0h expected %0h", tag, k, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int k, input logic [Ch-1:0] e_inc,
                         input logic [Ch-1:0] e_stb, input logic e_evt);
    chk({tag, "_inc"}, k, 32'(inc_pulse), 32'(e_inc));
    chk({tag, "_stable"}, k, 32'(btn_stable), 32'(e_stb));
    chk({tag, "_event"}, k, 32'(any_event), 32'(e_evt));
  endtask

  task automatic release_all();
    btn_in    = '0;
    repeat_en = 1'b0;
    step(8);
    chk("idle_stable", 0, 32'(btn_stable), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] bounce_pat;

    reset     = 1'b1;
    btn_in    = '0;
    repeat_en = 1'b0;
    step(2);
    chk_all("reset", 0, 2'b00, 2'b00, 1'b0);
    reset = 1'b0;
    step(2);
    chk_all("post_reset", 0, 2'b00, 2'b00, 1'b0);

    // Clean press, no repeat: single pulse after E4, stable from E4.
    btn_in = 2'b01;
    for (int k = 0; k < 20; k++) begin
      step(1);
      chk_all("clean", k, (k == 4) ? 2'b01 : 2'b00, (k >= 4) ? 2'b01 : 2'b00, k == 4);
    end
    // Release: stable drops at the 4th low edge, with a refresh strobe.
    btn_in = 2'b00;
    for (int k = 0; k < 7; k++) begin
      step(1);
      chk_all("clean_rel", k, 2'b00, (k < 4) ? 2'b01 : 2'b00, k == 4);
    end

    // Bounce reject: high 3, low 1, high 2, then low.
    bounce_pat = 12'b0000_0011_0111;
    for (int k = 0; k < 12; k++) begin
      btn_in = {1'b0, bounce_pat[k]};
      step(1);
      chk_all("bounce", k, 2'b00, 2'b00, 1'b0);
    end

    // Auto-repeat: pulses after E4, E14, E17, E20; release at E21, stable falls at E25.
    repeat_en = 1'b1;
    for (int k = 0; k <= 30; k++) begin
      btn_in = {1'b0, k <= 20};
      step(1);
      chk_all("repeat", k, (k inside {4, 14, 17, 20}) ? 2'b01 : 2'b00,
              (k >= 4 && k < 25) ? 2'b01 : 2'b00, k inside {4, 14, 17, 20, 25});
    end
    release_all();

    // Release bounce in REPEAT: low at E18-E19, back to HELD, next pulse E30 then E33.
    repeat_en = 1'b1;
    for (int k = 0; k <= 34; k++) begin
      btn_in = {1'b0, !(k inside {18, 19})};
      step(1);
      chk_all("rel_bounce", k, (k inside {4, 14, 17, 30, 33}) ? 2'b01 : 2'b00,
              (k >= 4) ? 2'b01 : 2'b00, k inside {4, 14, 17, 30, 33});
    end
    release_all();

    // repeat_en dropped during REPEAT (E18-E24), resumes with a full period.
    btn_in = 2'b01;
    for (int k = 0; k <= 31; k++) begin
      repeat_en = !(k >= 18 && k <= 24);
      step(1);
      chk_all("rep_gate", k, (k inside {4, 14, 17, 27, 30}) ? 2'b01 : 2'b00,
              (k >= 4) ? 2'b01 : 2'b00, k inside {4, 14, 17, 27, 30});
    end
    release_all();

    // Simultaneous press on both channels: one shared strobe.
    btn_in = 2'b11;
    for (int k = 0; k < 8; k++) begin
      step(1);
      chk_all("simul", k, (k == 4) ? 2'b11 : 2'b00, (k >= 4) ? 2'b11 : 2'b00, k == 4);
    end
    release_all();

    // Reset mid-operation: ch1 held, ch0 two edges into a press.
    btn_in = 2'b10;
    step(6);
    chk("pre_reset_stable", 0, 32'(btn_stable), 32'h2);
    btn_in = 2'b11;
    step(2);
    reset = 1'b1;
    step(1);
    chk_all("mid_reset", 0, 2'b00, 2'b00, 1'b0);
    reset = 1'b0;
    for (int k = 0; k < 7; k++) begin
      step(1);
      chk_all("after_reset", k, (k == 4) ? 2'b11 : 2'b00, (k >= 4) ? 2'b11 : 2'b00, k == 4);
    end
    release_all();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
